sim_result_checker: RTL

- Synthesizable, parametrised checker that grades a processor core's run, replacing hard-coded testbench checking logic.
- Compares the core's status stream against a loaded golden status table and counts mismatches.
- On a terminal status, sweeps data memory against golden memory and reports pass/fail with error counts.
- Sits beside the core in simulation and FPGA bring-up; all widths, depths and terminal codes are parameters.

---
 rtl/sim_result_checker.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/sim_result_checker.sv
// sim_result_checker: grades a processor run. It compares the core's status
// stream against a loaded golden status table. On a terminal status it sweeps
// data memory against golden memory, then reports pass/fail with error counts.
// Optional build macro: CHECKER_FIRST_MISMATCH_EN adds first-mismatch capture
// ports (o_fm_valid, o_fm_is_mem, o_fm_index, o_fm_exp, o_fm_got).
module sim_result_checker #(
    parameter int STATUS_W   = 2,
    parameter int STATUS_NUM = 88,
    parameter int MEM_DEPTH  = 64,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLE  = 12000,
    parameter int END_CODE   = 3,
    parameter int OVF_CODE   = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_gs_we,
    input  logic [$clog2(STATUS_NUM)-1:0] i_gs_addr,
    input  logic [STATUS_W-1:0]           i_gs_wdata,
    input  logic                          i_start,
    input  logic [STATUS_W-1:0]           i_status,
    input  logic                          i_status_valid,
    output logic                          o_mem_rd_en,
    output logic [$clog2(MEM_DEPTH)-1:0]  o_mem_addr,
    input  logic [DATA_W-1:0]             i_dut_rdata,
    input  logic [DATA_W-1:0]             i_gold_rdata,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_pass,
    output logic                          o_timeout,
    output logic [CNT_W-1:0]              o_status_err,
    output logic [CNT_W-1:0]              o_mem_err
`ifdef CHECKER_FIRST_MISMATCH_EN
    ,
    output logic                          o_fm_valid,
    output logic                          o_fm_is_mem,
    output logic [(($clog2(STATUS_NUM+1) > $clog2(MEM_DEPTH)) ? $clog2(STATUS_NUM+1) : $clog2(MEM_DEPTH))-1:0] o_fm_index,
    output logic [DATA_W-1:0]             o_fm_exp,
    output logic [DATA_W-1:0]             o_fm_got
`endif
);

    localparam int GA_W  = $clog2(STATUS_NUM);
    localparam int IDX_W = $clog2(STATUS_NUM + 1);   // index must be able to hold STATUS_NUM
    localparam int MA_W  = $clog2(MEM_DEPTH);
    localparam int MC_W  = $clog2(MEM_DEPTH + 1);    // sweep counter runs 0..MEM_DEPTH
    localparam int FI_W  = (IDX_W > MA_W) ? IDX_W : MA_W;

    localparam logic [IDX_W-1:0]    IDX_FULL = IDX_W'(STATUS_NUM);
    localparam logic [MC_W-1:0]     MEM_END  = MC_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]    CYC_LAST = CNT_W'(MAX_CYCLE - 1);
    localparam logic [STATUS_W-1:0] END_S    = STATUS_W'(END_CODE);
    localparam logic [STATUS_W-1:0] OVF_S    = STATUS_W'(OVF_CODE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEMCHK, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [STATUS_W-1:0]  gold_mem [STATUS_NUM];
    logic [STATUS_W-1:0]  gold_rd_q;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cyc_q, cyc_d;
    logic [CNT_W-1:0]     serr_q, serr_d;
    logic [CNT_W-1:0]     merr_q, merr_d;
    logic [MC_W-1:0]      mcnt_q, mcnt_d;
    logic                 cmp_q, cmp_d;
    logic                 timeout_q, timeout_d;
    logic                 gs_we;
    logic                 start_go;
    logic                 terminal;
    logic                 status_mis;
    logic                 mem_mis;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Table writes and run starts are only honoured while not grading.
    always_comb begin
        gs_we    = i_gs_we && (state_q == S_IDLE);
        start_go = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
        terminal = i_status_valid && ((i_status == END_S) || (i_status == OVF_S));
    end

    // Golden status RAM; the read is prefetched at idx_d so gold_rd_q always matches idx_q.
    always_ff @(posedge i_clk) begin
        if (gs_we) begin
            gold_mem[i_gs_addr] <= i_gs_wdata;
        end
        if (gs_we && (i_gs_addr == idx_d[GA_W-1:0])) begin
            gold_rd_q <= i_gs_wdata;
        end else begin
            gold_rd_q <= gold_mem[idx_d[GA_W-1:0]];
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cyc_q     <= '0;
            serr_q    <= '0;
            merr_q    <= '0;
            mcnt_q    <= '0;
            cmp_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            serr_q    <= serr_d;
            merr_q    <= merr_d;
            mcnt_q    <= mcnt_d;
            cmp_q     <= cmp_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state, counter updates and memory read strobes.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cyc_d       = cyc_q;
        serr_d      = serr_q;
        merr_d      = merr_q;
        mcnt_d      = mcnt_q;
        cmp_d       = 1'b0;
        timeout_d   = timeout_q;
        status_mis  = 1'b0;
        mem_mis     = 1'b0;
        o_mem_rd_en = 1'b0;
        o_mem_addr  = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_go) begin
                    state_d   = S_RUN;
                    idx_d     = '0;
                    cyc_d     = '0;
                    serr_d    = '0;
                    merr_d    = '0;
                    mcnt_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                cyc_d = sat_inc(cyc_q);
                if (i_status_valid) begin
                    // Past the end of the table every status is an error.
                    status_mis = (idx_q == IDX_FULL) || (i_status != gold_rd_q);
                    if (status_mis) begin
                        serr_d = sat_inc(serr_q);
                    end
                    if (idx_q != IDX_FULL) begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                // A terminal status beats an expiry in the same cycle.
                if (terminal) begin
                    state_d = S_MEMCHK;
                    mcnt_d  = '0;
                end else if (cyc_q >= CYC_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_MEMCHK: begin
                if (mcnt_q != MEM_END) begin
                    o_mem_rd_en = 1'b1;
                    o_mem_addr  = mcnt_q[MA_W-1:0];
                    cmp_d       = 1'b1;
                    mcnt_d      = mcnt_q + 1'b1;
                end else begin
                    state_d = S_DONE;
                end
                // Read data lags the strobe by one cycle; X/Z bits count as a mismatch.
                if (cmp_q) begin
                    mem_mis = (i_dut_rdata !== i_gold_rdata);
                    if (mem_mis) begin
                        merr_d = sat_inc(merr_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state and counters.
    always_comb begin
        o_busy       = (state_q == S_RUN) || (state_q == S_MEMCHK);
        o_done       = (state_q == S_DONE);
        o_timeout    = timeout_q;
        o_status_err = serr_q;
        o_mem_err    = merr_q;
        o_pass       = o_done && (serr_q == '0) && (merr_q == '0) && !timeout_q;
    end

`ifdef CHECKER_FIRST_MISMATCH_EN
    logic              fm_valid_q;
    logic              fm_is_mem_q;
    logic [FI_W-1:0]   fm_index_q;
    logic [DATA_W-1:0] fm_exp_q;
    logic [DATA_W-1:0] fm_got_q;
    logic [MC_W-1:0]   cmp_idx;

    assign cmp_idx = mcnt_q - 1'b1;

    // Capture the first mismatch of a run and hold it until reset or restart.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_go) begin
            fm_valid_q  <= 1'b0;
            fm_is_mem_q <= 1'b0;
            fm_index_q  <= '0;
            fm_exp_q    <= '0;
            fm_got_q    <= '0;
        end else if (!fm_valid_q && status_mis) begin
            fm_valid_q  <= 1'b1;
            fm_is_mem_q <= 1'b0;
            fm_index_q  <= FI_W'(idx_q);
            fm_exp_q    <= (idx_q == IDX_FULL) ? '0 : DATA_W'(gold_rd_q);
            fm_got_q    <= DATA_W'(i_status);
        end else if (!fm_valid_q && mem_mis) begin
            fm_valid_q  <= 1'b1;
            fm_is_mem_q <= 1'b1;
            fm_index_q  <= FI_W'(cmp_idx);
            fm_exp_q    <= i_gold_rdata;
            fm_got_q    <= i_dut_rdata;
        end
    end

    assign o_fm_valid  = fm_valid_q;
    assign o_fm_is_mem = fm_is_mem_q;
    assign o_fm_index  = fm_index_q;
    assign o_fm_exp    = fm_exp_q;
    assign o_fm_got    = fm_got_q;
`endif

endmodule
